// File: rtl/sram_axi_rd_arbiter.sv
// Purpose: arbitrates fetch-side and load-side SRAM-like reads onto one AXI AR/R channel pair.
// Latency: request-to-addr_ok is 2 cycles minimum; read data is forwarded combinationally from R.
// Backpressure: AR held stable until arready; a requester at MAX_OUTST in-flight reads is not granted.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration (default: fixed data priority).

module sram_axi_rd_arbiter #(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        reset,
  // fetch side
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // load side
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic [1:0]  data_size,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI AR
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_err
);

  localparam logic [2:0] LP_MAX = 3'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_AR_INST = 2'd1,
    S_AR_DATA = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [2:0]  r_cnt_inst;
  logic [2:0]  r_cnt_data;
  logic        r_arid0;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic        r_rd_err;

  logic        w_idle;
  logic        w_inst_cand;
  logic        w_data_cand;
  logic        w_pick_data;
  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_hs;
  logic        w_beat_ok_inst;
  logic        w_beat_ok_data;
  logic        w_inc_inst;
  logic        w_inc_data;
  logic        w_dec_inst;
  logic        w_dec_data;

  // A requester is a candidate only while it has room for another in-flight read
  assign w_idle      = (r_state == S_IDLE);
  assign w_inst_cand = inst_req & (r_cnt_inst < LP_MAX);
  assign w_data_cand = data_req & (r_cnt_data < LP_MAX);

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = data was granted last, 0 = inst was granted last
  logic r_last_data;

  assign w_pick_data = w_data_cand & (~w_inst_cand | ~r_last_data);

  // Remember the last winner so a tie goes to the other requester next time
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_data <= 1'b0;
    end else if (w_grant_data) begin
      r_last_data <= 1'b1;
    end else if (w_grant_inst) begin
      r_last_data <= 1'b0;
    end
  end
`else
  assign w_pick_data = w_data_cand;
`endif

  assign w_grant_data = w_idle & w_pick_data;
  assign w_grant_inst = w_idle & w_inst_cand & ~w_pick_data;

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a grant is committed until the AR handshake completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_data) begin
          w_state_nxt = S_AR_DATA;
        end else if (w_grant_inst) begin
          w_state_nxt = S_AR_INST;
        end
      end
      S_AR_INST, S_AR_DATA: begin
        if (arready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: everything is forced low while reset is held
  always_comb begin
    arvalid      = 1'b0;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    if (!reset) begin
      arvalid      = (r_state != S_IDLE);
      inst_addr_ok = (r_state == S_AR_INST) & arready;
      data_addr_ok = (r_state == S_AR_DATA) & arready;
    end
  end

  assign w_hs = arvalid & arready;

  // Capture the winning request so AR fields stay stable while arvalid waits for arready
  always_ff @(posedge clk) begin
    if (reset) begin
      r_araddr <= 32'd0;
      r_arid0  <= 1'b0;
      r_arsize <= 3'd0;
    end else if (w_grant_data) begin
      r_araddr <= data_addr;
      r_arid0  <= 1'b1;
      r_arsize <= {1'b0, data_size};
    end else if (w_grant_inst) begin
      r_araddr <= inst_addr;
      r_arid0  <= 1'b0;
      r_arsize <= 3'd2;
    end
  end

  assign araddr  = reset ? 32'd0 : r_araddr;
  assign arid    = reset ? 4'd0 : {3'b000, r_arid0};
  assign arsize  = reset ? 3'd0 : r_arsize;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign rready  = 1'b1;

  // An R beat is only legal for ID 0/1 with a read actually outstanding on that ID
  assign w_beat_ok_inst = ~reset & rvalid & (rid == 4'd0) & (r_cnt_inst != 3'd0);
  assign w_beat_ok_data = ~reset & rvalid & (rid == 4'd1) & (r_cnt_data != 3'd0);

  assign inst_data_ok = w_beat_ok_inst;
  assign data_data_ok = w_beat_ok_data;
  assign inst_rdata   = reset ? 32'd0 : rdata;
  assign data_rdata   = reset ? 32'd0 : rdata;

  assign w_inc_inst = w_hs & ~r_arid0;
  assign w_inc_data = w_hs &  r_arid0;
  assign w_dec_inst = w_beat_ok_inst & rlast;
  assign w_dec_data = w_beat_ok_data & rlast;

  // Outstanding counters: simultaneous increment and decrement cancel; saturate rather than wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_inst <= 3'd0;
      r_cnt_data <= 3'd0;
    end else begin
      case ({w_inc_inst, w_dec_inst})
        2'b10:   r_cnt_inst <= (r_cnt_inst == 3'd7) ? r_cnt_inst : r_cnt_inst + 3'd1;
        2'b01:   r_cnt_inst <= r_cnt_inst - 3'd1;
        default: r_cnt_inst <= r_cnt_inst;
      endcase
      case ({w_inc_data, w_dec_data})
        2'b10:   r_cnt_data <= (r_cnt_data == 3'd7) ? r_cnt_data : r_cnt_data + 3'd1;
        2'b01:   r_cnt_data <= r_cnt_data - 3'd1;
        default: r_cnt_data <= r_cnt_data;
      endcase
    end
  end

  // Sticky error for any R beat that cannot be matched to an outstanding read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_err <= 1'b0;
    end else if (rvalid & ~w_beat_ok_inst & ~w_beat_ok_data) begin
      r_rd_err <= 1'b1;
    end
  end

  assign rd_err = r_rd_err;

endmodule

// File: tb/tb_sram_axi_rd_arbiter.sv
// Bench for sram_axi_rd_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
// Honours ARB_ROUND_ROBIN_EN in the model the same way the design does.

module tb_sram_axi_rd_arbiter;

  localparam int MAX_OUTST = 2;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [31:0] data_addr;
  logic [1:0]  data_size;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        rd_err;

  sram_axi_rd_arbiter #(.MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one committed-but-unaccepted AR at most, plus per-ID in-flight counts
  bit          m_pend;
  int          m_who;       // 0 = inst, 1 = data
  logic [31:0] m_addr;
  logic [2:0]  m_size;
  int          m_cnt[2];
  bit          m_err;
  int          m_last;      // last granted requester (round-robin build only)

  task automatic model_reset();
    m_pend = 0; m_who = 0; m_addr = '0; m_size = '0;
    m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0; m_last = 0;
  endtask

  // One clock cycle: drive inputs after the edge, check at the falling edge, advance the model
  task automatic step(input logic rst, input logic ireq, input logic [31:0] ia,
                      input logic dreq, input logic [31:0] da, input logic [1:0] ds,
                      input logic ardy, input logic rv, input logic [3:0] ri,
                      input logic [31:0] rd, input logic rl);
    bit exp_arv, exp_hs, ok_i, ok_d, bad, el_i, el_d, pick_d;
    int c0, c1;
    @(posedge clk);
    #1;
    reset = rst; inst_req = ireq; inst_addr = ia; data_req = dreq; data_addr = da;
    data_size = ds; arready = ardy; rvalid = rv; rid = ri; rdata = rd; rlast = rl;
    @(negedge clk);
    c0 = m_cnt[0]; c1 = m_cnt[1];
    exp_arv = !rst && m_pend;
    exp_hs  = exp_arv && ardy;
    ok_i    = !rst && rv && (ri == 4'd0) && (c0 > 0);
    ok_d    = !rst && rv && (ri == 4'd1) && (c1 > 0);
    bad     = !rst && rv && !ok_i && !ok_d;

    chk("arvalid", arvalid, exp_arv);
    chk("inst_addr_ok", inst_addr_ok, exp_hs && m_who == 0);
    chk("data_addr_ok", data_addr_ok, exp_hs && m_who == 1);
    chk("inst_data_ok", inst_data_ok, ok_i);
    chk("data_data_ok", data_data_ok, ok_d);
    chk("rd_err", rd_err, m_err);
    chk("arlen", arlen, 32'd0);
    chk("arburst", arburst, 32'd1);
    chk("rready", rready, 32'd1);
    if (exp_arv) begin
      chk("araddr", araddr, m_addr);
      chk("arid", arid, m_who);
      chk("arsize", arsize, m_size);
    end
    if (rst) begin
      chk("rst_araddr", araddr, 32'd0);
      chk("rst_arid", arid, 32'd0);
      chk("rst_arsize", arsize, 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
    end
    if (ok_i) chk("inst_rdata", inst_rdata, rd);
    if (ok_d) chk("data_rdata", data_rdata, rd);

    if (rst) begin
      model_reset();
    end else begin
      if (bad) m_err = 1;
      if (ok_i && rl) m_cnt[0] = m_cnt[0] - 1;
      if (ok_d && rl) m_cnt[1] = m_cnt[1] - 1;
      if (exp_hs) begin
        m_cnt[m_who] = m_cnt[m_who] + 1;
        m_pend = 0;
      end else if (!m_pend) begin
        el_i = ireq && (c0 < MAX_OUTST);
        el_d = dreq && (c1 < MAX_OUTST);
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = el_d && (!el_i || m_last == 0);
`else
        pick_d = el_d;
`endif
        if (pick_d) begin
          m_pend = 1; m_who = 1; m_addr = da; m_size = {1'b0, ds}; m_last = 1;
        end else if (el_i) begin
          m_pend = 1; m_who = 0; m_addr = ia; m_size = 3'd2; m_last = 0;
        end
      end
    end
  endtask

  task automatic idle(input logic rst);
    step(rst, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic beat(input logic [3:0] ri, input logic [31:0] rd);
    step(0, 0, 0, 0, 0, 0, 1, 1, ri, rd, 1);
  endtask

  int npulse;

  initial begin
    reset = 1; inst_req = 0; inst_addr = 0; data_req = 0; data_addr = 0; data_size = 0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rlast = 0;
    model_reset();
    idle(1);
    idle(1);
    idle(0);

    // Single fetch: grant, then AR + addr_ok, then data returned in the same cycle as R
    step(0, 1, 32'h1C000000, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("s1_addr_ok", inst_addr_ok, 32'd1);
    chk("s1_arsize", arsize, 32'd2);
    beat(4'd0, 32'h02800000);
    chk("s1_rdata", inst_rdata, 32'h02800000);

    // Simultaneous requests: data wins (fixed priority, or round-robin after an inst grant)
    step(0, 1, 32'h1C000040, 1, 32'h00001000, 2'd0, 1, 0, 0, 0, 0);
    step(0, 1, 32'h1C000040, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("s2_first_arid", arid, 32'd1);
    chk("s2_first_arsize", arsize, 32'd0);
    step(0, 1, 32'h1C000040, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("s2_second_addr_ok", inst_addr_ok, 32'd1);
    beat(4'd1, 32'hDEAD0001);
    beat(4'd0, 32'hDEAD0000);

    // arready stalled five cycles; request dropped during the stall still completes
    step(0, 1, 32'h1C000100, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, (i == 0), 32'h1C000100, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("s3_addr_ok_after_drop", inst_addr_ok, 32'd1);
    beat(4'd0, 32'h00000033);

    // Outstanding limit: only MAX_OUTST inst ARs accepted until a beat returns
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 32'h1C000200 + 32'(i * 4), 0, 0, 0, 1, 0, 0, 0, 0);
      if (inst_addr_ok) npulse++;
    end
    chk("s4_outst_cap", npulse, MAX_OUTST);
    npulse = 0;
    step(0, 1, 32'h1C000300, 0, 0, 0, 1, 1, 4'd0, 32'h44, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 32'h1C000300, 0, 0, 0, 1, 0, 0, 0, 0);
      if (inst_addr_ok) npulse++;
    end
    chk("s4_third_issued", npulse, 1);
    beat(4'd0, 1); beat(4'd0, 2);

    // Unmatched R beat: sticky error, no data_ok, cleared only by reset
    beat(4'd1, 32'h55);
    chk("s5_no_data_ok", data_data_ok, 32'd0);
    idle(0);
    chk("s5_err_set", rd_err, 32'd1);
    idle(0); idle(0);
    chk("s5_err_sticky", rd_err, 32'd1);
    idle(1);
    idle(0);
    chk("s5_err_cleared", rd_err, 32'd0);

    // Reset while arvalid is high drops the AR without a handshake
    step(0, 1, 32'h1C000400, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 32'h1C000400, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("s6_arvalid_before", arvalid, 32'd1);
    step(1, 1, 32'h1C000400, 0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    chk("s6_arvalid_after", arvalid, 32'd0);
    beat(4'd0, 32'h66);
    chk("s6_counter_zero", inst_data_ok, 32'd0);
    idle(1);

    // Randomized traffic in phases of differing R-return rate
    for (int i = 0; i < 3000; i++) begin
      int phase, sel;
      logic rv_r;
      logic [3:0] rid_r;
      phase = (i / 300) % 3;
      case (phase)
        0:       rv_r = ($urandom % 4) == 0;
        1:       rv_r = ($urandom % 2) == 0;
        default: rv_r = ($urandom % 10) == 0;
      endcase
      sel = $urandom % 16;
      if (sel < 7)       rid_r = 4'd0;
      else if (sel < 14) rid_r = 4'd1;
      else               rid_r = 4'($urandom_range(2, 15));
      step($urandom_range(0, 199) == 0, 1'($urandom % 2), $urandom,
           1'($urandom % 2), $urandom, 2'($urandom_range(0, 2)),
           ($urandom % 4) != 0, rv_r, rid_r, $urandom, ($urandom % 8) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_axi_rd_arbiter.md
SRAM_AXI_RD_ARBITER -- requirements
Module: sram_axi_rd_arbiter

Interface
REQ-001 Parameter: MAX_OUTST, default 2, maximum in-flight reads per requester (1..7).
REQ-002 Port: clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 Port: reset  in  1  synchronous active-high reset.
REQ-004 Ports: inst_req in 1 and inst_addr in 32 carry the fetch-side SRAM-like request.
REQ-005 Ports: inst_addr_ok out 1, inst_data_ok out 1 and inst_rdata out 32 carry the fetch-side SRAM-like response.
REQ-006 Ports: data_req in 1, data_addr in 32 and data_size in 2 (0=byte, 1=half, 2=word) carry the load-side SRAM-like request.
REQ-007 Ports: data_addr_ok out 1, data_data_ok out 1 and data_rdata out 32 carry the load-side SRAM-like response.
REQ-008 AXI AR ports: arid out 4, araddr out 32, arlen out 8, arsize out 3, arburst out 2, arvalid out 1, arready in 1.
REQ-009 AXI R ports: rid in 4, rdata in 32, rlast in 1, rvalid in 1, rready out 1.
REQ-010 Port: rd_err  out  1  sticky flag for an R beat whose ID matches no outstanding read.

Function
REQ-011 The AR FSM SHALL have three states: IDLE, AR_INST and AR_DATA.
REQ-012 In IDLE, data_req with the data counter below MAX_OUTST SHALL grant AR_DATA; otherwise, inst_req with the inst counter below MAX_OUTST SHALL grant AR_INST; data has fixed priority.
REQ-013 On grant, the FSM SHALL latch the address, ID (inst=0, data=1) and size (inst=2, data=data_size) into AR registers, and SHALL assert arvalid from the next cycle.
REQ-014 While in AR_x, arvalid, araddr, arid and arsize SHALL stay stable until arvalid&arready.
REQ-015 On arvalid&arready, the FSM SHALL pulse the matching *_addr_ok for exactly that cycle and return to IDLE.
REQ-016 A grant is committed: a deasserted *_req after grant SHALL NOT cancel the AR, and addr_ok SHALL still pulse.
REQ-017 Request-to-addr_ok latency SHALL be at least 2 cycles (grant cycle plus a cycle with arvalid high); with arready held high it SHALL be exactly 2.
REQ-018 The AR channel SHALL drive arlen=0, arburst=2'b01 and the upper three bits of arid as 0.
REQ-019 rready SHALL be constant 1 after reset.
REQ-020 An R beat with rvalid and rid=0 SHALL pulse inst_data_ok with inst_rdata=rdata in the same cycle (combinational path).
REQ-021 An R beat with rvalid and rid=1 SHALL pulse data_data_ok with data_rdata=rdata in the same cycle.
REQ-022 Each requester SHALL have a 3-bit outstanding counter that is incremented on its AR handshake and decremented on its R beat (rvalid&rlast).
REQ-023 If the increment and decrement for the same counter happen in the same cycle, the counter SHALL be unchanged.
REQ-024 A counter at MAX_OUTST SHALL block its requester's grant; the counter SHALL never wrap.
REQ-025 An R beat whose counter is 0, or whose rid is greater than 1, SHALL set rd_err, SHALL NOT pulse any data_ok, and SHALL leave the counters unchanged.
REQ-026 Read data SHALL be returned in AXI order per ID; no reordering buffer exists.

Reset
REQ-027 Reset SHALL force the FSM to IDLE, both counters to 0 and rd_err to 0.
REQ-028 During reset, arvalid, both *_addr_ok and both *_data_ok SHALL be 0, and araddr, arid, arsize, inst_rdata and data_rdata SHALL all be 0.
REQ-029 Reset asserted mid-AR SHALL drop arvalid in the next cycle without completing the handshake.
REQ-030 R beats arriving after reset SHALL be handled per REQ-025.

Configuration
REQ-031 The arbitration policy SHALL be selected by macro ARB_ROUND_ROBIN_EN.
REQ-032 When ARB_ROUND_ROBIN_EN is defined, a 1-bit last-grant register SHALL be added (reset value: inst); on simultaneous eligible requests, the requester not granted last SHALL win.
REQ-033 When ARB_ROUND_ROBIN_EN is undefined, fixed data priority per REQ-012 SHALL apply and no last-grant register SHALL exist.

Verification
REQ-034 Scenario: inst_req with addr 0x1C000000 and arready=1 -> cycle+1 arvalid, arid=0, arsize=2, arlen=0; inst_addr_ok pulses at cycle+1; R rid=0 rdata=0x02800000 -> inst_data_ok with inst_rdata=0x02800000 in the same cycle.
REQ-035 Scenario: inst_req and data_req (0x00001000, size 0) in the same cycle -> data granted first with arid=1 and arsize=0, inst follows; with ARB_ROUND_ROBIN_EN defined and last grant=data, inst is granted first.
REQ-036 Scenario: arready held 0 for 5 cycles -> arvalid and araddr stable for all 5 cycles; inst_req dropped in cycle 2 -> inst_addr_ok still pulses on the handshake.
REQ-037 Scenario: 3 inst requests with MAX_OUTST=2 and no R beats -> only 2 AR handshakes and the third addr_ok withheld; one R beat to rid 0 -> third AR issues.
REQ-038 Scenario: R beat rid=1 with data counter 0 -> rd_err=1 and stays 1, no data_data_ok; reset -> rd_err=0.
REQ-039 Scenario: reset while arvalid=1 -> arvalid=0 the following cycle, both counters 0, FSM in IDLE.
